// File: rtl/branch_flush_tracker_pkg.sv
// Shared types for the branch flush tracker: FSM states and the branch-resolution record.
package branch_flush_tracker_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int TICKET_W_DEF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                    taken;
    logic                    csr;
    logic [XLEN_DEF-1:0]     target;
    logic [XLEN_DEF-1:0]     pc;
    logic                    is_comp;
    logic [TICKET_W_DEF-1:0] ticket;
    logic                    rat_id;
  } resolve_t;

endpackage

// File: rtl/branch_flush_tracker_if.sv
// Decode, resolution and flush signals of the branch flush tracker, bundled for the top-level port.
interface branch_flush_tracker_if #(
  parameter int FETCH_W  = 2,
  parameter int DEPTH    = 8,
  parameter int TICKET_W = 3,
  parameter int XLEN     = 32
);
  logic [FETCH_W-1:0]      dec_valid;
  logic [FETCH_W-1:0]      dec_is_branch;
  logic [FETCH_W*XLEN-1:0] dec_pc;
  logic                    dec_ready;

  logic                    res_valid;
  logic                    res_ready;
  logic                    res_taken;
  logic                    res_csr;
  logic [XLEN-1:0]         res_target;
  logic [XLEN-1:0]         res_pc;
  logic                    res_is_comp;
  logic [TICKET_W-1:0]     res_ticket;
  logic                    res_rat_id;

  logic                    flush;
  logic [XLEN-1:0]         flush_pc;
  logic [TICKET_W-1:0]     flush_ticket;
  logic                    flush_rat_id;
  logic [$clog2(DEPTH):0]  occupancy;
  logic                    err_underflow;

  modport master (
    output dec_valid, dec_is_branch, dec_pc,
    input  dec_ready,
    output res_valid, res_taken, res_csr, res_target, res_pc, res_is_comp, res_ticket, res_rat_id,
    input  res_ready,
    input  flush, flush_pc, flush_ticket, flush_rat_id, occupancy, err_underflow
  );

  modport slave (
    input  dec_valid, dec_is_branch, dec_pc,
    output dec_ready,
    input  res_valid, res_taken, res_csr, res_target, res_pc, res_is_comp, res_ticket, res_rat_id,
    output res_ready,
    output flush, flush_pc, flush_ticket, flush_rat_id, occupancy, err_underflow
  );
endinterface

// File: rtl/branch_flush_tracker_flush_fifo_mp.sv
// Circular FIFO accepting up to FETCH_W pushes and one pop per cycle; an empty FIFO
// presents the first same-cycle push at its head so it can be popped immediately.
module flush_fifo_mp #(
  parameter int FETCH_W = 2,
  parameter int DEPTH   = 8,
  parameter int XLEN    = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1,
  localparam int PCNT_W = $clog2(FETCH_W + 1)
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [PCNT_W-1:0]       push_cnt,
  input  logic [FETCH_W*XLEN-1:0] push_data,
  input  logic                    pop,
  output logic [XLEN-1:0]         head,
  output logic                    head_vld,
  output logic [CNT_W-1:0]        count
);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  // With count_q == 0 the read and write pointers coincide, so a bypassed pop
  // simply steps the read pointer over the entry being written this cycle.
  assign head     = (count_q != '0) ? mem[rd_ptr] : push_data[XLEN-1:0];
  assign head_vld = (count_q != '0) || (push_cnt != '0);
  assign count    = count_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (PCNT_W'(k) < push_cnt)
        mem[wr_ptr + PTR_W'(k)] <= push_data[k*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (clr) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(push_cnt);
      rd_ptr  <= rd_ptr + PTR_W'(pop);
      count_q <= count_q + CNT_W'(push_cnt) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/branch_flush_tracker.sv
// Tracks the PC fetched after each predicted branch and raises a one-cycle flush
// with the correct restart address when a resolved branch disagrees with it.
module branch_flush_tracker
  import branch_flush_tracker_pkg::*;
#(
  parameter int FETCH_W  = 2,
  parameter int DEPTH    = 8,
  parameter int TICKET_W = TICKET_W_DEF,
  parameter int XLEN     = XLEN_DEF
)(
  input  logic                  clk,
  input  logic                  rst_n,
  branch_flush_tracker_if.slave bus
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int PCNT_W = $clog2(FETCH_W + 1);

  function automatic logic [XLEN-1:0] next_pc(input resolve_t r);
    if (r.taken || r.csr)
      return r.target;
    return r.pc + (r.is_comp ? XLEN'(2) : XLEN'(4));
  endfunction

  resolve_t                res;
  state_t                  state_p1, state_d;
  logic                    pending_p1, pending_d;
  logic [XLEN-1:0]         wait_pc_p1;
  logic [TICKET_W-1:0]     wait_ticket_p1;
  logic                    wait_rat_p1;
  logic                    flush_p1;
  logic [XLEN-1:0]         flush_pc_p1;
  logic [TICKET_W-1:0]     flush_ticket_p1;
  logic                    flush_rat_p1;
  logic                    err_p1;

  logic [CNT_W-1:0]        count;
  logic [XLEN-1:0]         head;
  logic                    head_vld;
  logic                    pop;
  logic [PCNT_W-1:0]       push_cnt;
  logic [FETCH_W*XLEN-1:0] push_data;
  int unsigned             push_n;

  logic                    dec_ready, dec_acc, res_ready, res_fire;
  logic [XLEN-1:0]         correct_pc;
  logic                    mispredict, save, underflow;
  logic [XLEN-1:0]         mp_pc;
  logic [TICKET_W-1:0]     mp_ticket;
  logic                    mp_rat;

  assign res = '{taken: bus.res_taken, csr: bus.res_csr, target: bus.res_target,
                 pc: bus.res_pc, is_comp: bus.res_is_comp, ticket: bus.res_ticket,
                 rat_id: bus.res_rat_id};

  assign dec_ready  = count <= CNT_W'(DEPTH - FETCH_W);
  assign dec_acc    = (|bus.dec_valid) && dec_ready;
  assign res_ready  = (state_p1 == ST_IDLE) && !flush_p1;
  assign res_fire   = bus.res_valid && res_ready;
  assign correct_pc = next_pc(res);

  // Stage p0: compact the successor PCs of this decode group in program order.
  always_comb begin
    push_data = '0;
    push_n    = 0;
    pending_d = 1'b0;
    if (pending_p1) begin
      push_data[XLEN-1:0] = bus.dec_pc[XLEN-1:0];
      push_n              = 1;
    end
    for (int i = 0; i < FETCH_W - 1; i++) begin
      if (bus.dec_valid[i] && bus.dec_is_branch[i] && bus.dec_valid[i+1]) begin
        push_data[push_n*XLEN +: XLEN] = bus.dec_pc[(i+1)*XLEN +: XLEN];
        push_n                         = push_n + 1;
      end
    end
    // Valid slots are contiguous, so the last valid slot decides pending.
    for (int i = 0; i < FETCH_W; i++) begin
      if (bus.dec_valid[i])
        pending_d = bus.dec_is_branch[i];
    end
  end

  assign push_cnt = dec_acc ? PCNT_W'(push_n) : '0;

  always_comb begin
    state_d    = state_p1;
    pop        = 1'b0;
    mispredict = 1'b0;
    save       = 1'b0;
    underflow  = 1'b0;
    mp_pc      = correct_pc;
    mp_ticket  = res.ticket;
    mp_rat     = res.rat_id;
    case (state_p1)
      ST_IDLE: begin
        if (res_fire) begin
          if (res.csr) begin
            mispredict = 1'b1;
          end else if (count != '0) begin
            pop        = 1'b1;
            mispredict = (head != correct_pc);
          end else if (pending_p1) begin
            save    = 1'b1;
            state_d = ST_WAIT;
          end else begin
            underflow = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (head_vld) begin
          pop        = 1'b1;
          mispredict = (head != wait_pc_p1);
          mp_pc      = wait_pc_p1;
          mp_ticket  = wait_ticket_p1;
          mp_rat     = wait_rat_p1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (mispredict)
      state_d = ST_IDLE;
  end

  flush_fifo_mp #(
    .FETCH_W (FETCH_W),
    .DEPTH   (DEPTH),
    .XLEN    (XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (mispredict),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .head_vld  (head_vld),
    .count     (count)
  );

  // Stage p1: registered control, flush pulse and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1        <= ST_IDLE;
      pending_p1      <= 1'b0;
      flush_p1        <= 1'b0;
      flush_pc_p1     <= '0;
      flush_ticket_p1 <= '0;
      flush_rat_p1    <= 1'b0;
      err_p1          <= 1'b0;
    end else begin
      state_p1   <= state_d;
      flush_p1   <= mispredict;
      err_p1     <= err_p1 | underflow;
      if (mispredict)
        pending_p1 <= 1'b0;
      else if (dec_acc)
        pending_p1 <= pending_d;
      if (mispredict) begin
        flush_pc_p1     <= mp_pc;
        flush_ticket_p1 <= mp_ticket;
        flush_rat_p1    <= mp_rat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (save) begin
      wait_pc_p1     <= correct_pc;
      wait_ticket_p1 <= res.ticket;
      wait_rat_p1    <= res.rat_id;
    end
  end

  assign bus.dec_ready     = dec_ready;
  assign bus.res_ready     = res_ready;
  assign bus.flush         = flush_p1;
  assign bus.flush_pc      = flush_pc_p1;
  assign bus.flush_ticket  = flush_ticket_p1;
  assign bus.flush_rat_id  = flush_rat_p1;
  assign bus.occupancy     = count;
  assign bus.err_underflow = err_p1;

endmodule

// File: tb/tb_branch_flush_tracker.sv
// Bench for branch_flush_tracker: directed vector table, corner sequences, then random traffic vs a queue model.
module tb_branch_flush_tracker;
  localparam int FW = 2, DP = 8, TW = 3, XL = 32, NV = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_flush_tracker_if #(.FETCH_W(FW), .DEPTH(DP), .TICKET_W(TW), .XLEN(XL)) bus ();

  branch_flush_tracker #(.FETCH_W(FW), .DEPTH(DP), .TICKET_W(TW), .XLEN(XL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  dv, db;
    logic [31:0] pc0, pc1;
    logic        rv, tk, csr;
    logic [31:0] tgt, rpc;
    logic        comp;
    logic [2:0]  tkt;
    logic        rat;
    logic        e_flush;
    logic [31:0] e_fpc;
    logic [2:0]  e_tkt;
    logic        e_rat;
    logic [3:0]  e_occ;
    logic        e_dr, e_rr;
  } vec_t;

  vec_t tbl [NV];
  int n_vec = 0, n_bad = 0;

  // queue-level reference model state
  logic [31:0] mq[$];
  bit          m_pend, m_wait, m_flush, m_err;
  logic [31:0] m_spc, m_fpc;
  logic [2:0]  m_stk, m_ftk;
  logic        m_srat, m_frat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] dv, db, input logic [31:0] pc0, pc1,
                       input logic rv, tk, csr, input logic [31:0] tgt, rpc,
                       input logic comp, input logic [2:0] tkt, input logic rat);
    bus.dec_valid     = dv;
    bus.dec_is_branch = db;
    bus.dec_pc        = {pc1, pc0};
    bus.res_valid     = rv;
    bus.res_taken     = tk;
    bus.res_csr       = csr;
    bus.res_target    = tgt;
    bus.res_pc        = rpc;
    bus.res_is_comp   = comp;
    bus.res_ticket    = tkt;
    bus.res_rat_id    = rat;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic dgrp(input logic [1:0] dv, db, input logic [31:0] pc0, pc1);
    drive(dv, db, pc0, pc1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic rslv(input logic tk, csr, input logic [31:0] tgt, rpc, input logic comp,
                      input logic [2:0] tkt, input logic rat);
    drive(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, tk, csr, tgt, rpc, comp, tkt, rat);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t vd(input logic [1:0] dv, db, input logic [31:0] pc0, pc1,
                              input logic [3:0] occ, input logic rr);
    vec_t v;
    v = '0;
    v.dv = dv; v.db = db; v.pc0 = pc0; v.pc1 = pc1;
    v.e_occ = occ; v.e_dr = 1'b1; v.e_rr = rr;
    return v;
  endfunction

  function automatic vec_t vr(input logic tk, csr, input logic [31:0] tgt, rpc, input logic comp,
                              input logic [2:0] tkt, input logic rat, input logic ef,
                              input logic [31:0] efpc, input logic [3:0] occ, input logic rr);
    vec_t v;
    v = '0;
    v.rv = 1'b1; v.tk = tk; v.csr = csr; v.tgt = tgt; v.rpc = rpc; v.comp = comp;
    v.tkt = tkt; v.rat = rat;
    v.e_flush = ef; v.e_fpc = efpc; v.e_tkt = tkt; v.e_rat = rat;
    v.e_occ = occ; v.e_dr = 1'b1; v.e_rr = rr;
    return v;
  endfunction

  function automatic vec_t vi(input logic [3:0] occ, input logic rr);
    vec_t v;
    v = '0;
    v.e_occ = occ; v.e_dr = 1'b1; v.e_rr = rr;
    return v;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    vec_t v;

    tbl[0]  = vd(2'b11, 2'b01, 32'h100, 32'h104, 4'd1, 1'b1);
    tbl[1]  = vr(1'b0, 1'b0, 32'h0, 32'h100, 1'b0, 3'd1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b1);
    tbl[2]  = vd(2'b11, 2'b10, 32'h200, 32'h204, 4'd0, 1'b1);
    tbl[3]  = vd(2'b11, 2'b00, 32'h400, 32'h404, 4'd1, 1'b1);
    tbl[4]  = vr(1'b1, 1'b0, 32'h300, 32'h204, 1'b0, 3'd5, 1'b1, 1'b1, 32'h300, 4'd0, 1'b0);
    tbl[5]  = vi(4'd0, 1'b1);
    tbl[6]  = vd(2'b01, 2'b01, 32'h500, 32'h0, 4'd0, 1'b1);
    tbl[7]  = vr(1'b0, 1'b0, 32'h0, 32'h500, 1'b0, 3'd2, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0);
    tbl[8]  = vd(2'b11, 2'b00, 32'h504, 32'h508, 4'd0, 1'b1);
    tbl[9]  = vd(2'b01, 2'b01, 32'h500, 32'h0, 4'd0, 1'b1);
    tbl[10] = vr(1'b0, 1'b0, 32'h0, 32'h500, 1'b0, 3'd3, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0);
    tbl[11] = vi(4'd0, 1'b0);
    tbl[12] = vd(2'b11, 2'b00, 32'h600, 32'h604, 4'd0, 1'b0);
    tbl[12].e_flush = 1'b1; tbl[12].e_fpc = 32'h504; tbl[12].e_tkt = 3'd3; tbl[12].e_rat = 1'b0;
    tbl[13] = vi(4'd0, 1'b1);
    tbl[14] = vd(2'b11, 2'b11, 32'h700, 32'h704, 4'd1, 1'b1);
    tbl[15] = vd(2'b11, 2'b01, 32'h708, 32'h70c, 4'd3, 1'b1);
    tbl[16] = vr(1'b0, 1'b1, 32'h80000000, 32'h1234, 1'b0, 3'd7, 1'b1, 1'b1, 32'h80000000, 4'd0, 1'b0);
    tbl[17] = vr(1'b0, 1'b1, 32'h9000, 32'h0, 1'b0, 3'd6, 1'b0, 1'b0, 32'h0, 4'd0, 1'b1);

    // reset state
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_flush_pc", bus.flush_pc, 32'd0);
    chk("rst_occ", 32'(bus.occupancy), 32'd0);
    chk("rst_dec_ready", 32'(bus.dec_ready), 32'd1);
    chk("rst_res_ready", 32'(bus.res_ready), 32'd1);
    chk("rst_err", 32'(bus.err_underflow), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      drive(v.dv, v.db, v.pc0, v.pc1, v.rv, v.tk, v.csr, v.tgt, v.rpc, v.comp, v.tkt, v.rat);
      step();
      chk($sformatf("t%0d_flush", i), 32'(bus.flush), 32'(v.e_flush));
      if (v.e_flush) begin
        chk($sformatf("t%0d_flush_pc", i), bus.flush_pc, v.e_fpc);
        chk($sformatf("t%0d_ticket", i), 32'(bus.flush_ticket), 32'(v.e_tkt));
        chk($sformatf("t%0d_rat", i), 32'(bus.flush_rat_id), 32'(v.e_rat));
      end
      chk($sformatf("t%0d_occ", i), 32'(bus.occupancy), 32'(v.e_occ));
      chk($sformatf("t%0d_dec_ready", i), 32'(bus.dec_ready), 32'(v.e_dr));
      chk($sformatf("t%0d_res_ready", i), 32'(bus.res_ready), 32'(v.e_rr));
      chk($sformatf("t%0d_err", i), 32'(bus.err_underflow), 32'd0);
    end
    idle();
    step();

    // fill to DEPTH-1, then a group that must be refused
    for (int k = 0; k < DP - 1; k++) begin
      dgrp(2'b11, 2'b01, 32'h1000 + 32'(16 * k), 32'h1004 + 32'(16 * k));
      step();
      chk($sformatf("fill%0d_occ", k), 32'(bus.occupancy), 32'(k + 1));
      chk($sformatf("fill%0d_dec_ready", k), 32'(bus.dec_ready), ((k + 1) <= DP - FW) ? 32'd1 : 32'd0);
    end
    dgrp(2'b11, 2'b01, 32'h2000, 32'h2004);
    step();
    chk("full_refused_occ", 32'(bus.occupancy), 32'(DP - 1));
    for (int k = 0; k < DP - 1; k++) begin
      rslv(1'b0, 1'b0, 32'h0, 32'h1000 + 32'(16 * k), 1'b0, 3'(k), 1'b0);
      step();
      chk($sformatf("drain%0d_flush", k), 32'(bus.flush), 32'd0);
      chk($sformatf("drain%0d_occ", k), 32'(bus.occupancy), 32'(DP - 2 - k));
    end
    rslv(1'b0, 1'b0, 32'h0, 32'h3000, 1'b0, 3'd1, 1'b0);
    step();
    chk("underflow_err", 32'(bus.err_underflow), 32'd1);
    chk("underflow_flush", 32'(bus.flush), 32'd0);
    chk("underflow_res_ready", 32'(bus.res_ready), 32'd1);
    dgrp(2'b11, 2'b01, 32'h700, 32'h702);
    step();
    chk("comp_push_occ", 32'(bus.occupancy), 32'd1);
    rslv(1'b0, 1'b0, 32'h0, 32'h700, 1'b1, 3'd2, 1'b1);
    step();
    chk("comp_flush", 32'(bus.flush), 32'd0);
    chk("comp_occ", 32'(bus.occupancy), 32'd0);
    chk("comp_err_sticky", 32'(bus.err_underflow), 32'd1);

    // asynchronous reset in the middle of a busy state
    dgrp(2'b11, 2'b01, 32'h800, 32'h804);
    step();
    dgrp(2'b11, 2'b11, 32'h900, 32'h904);
    step();
    chk("pre_rst_occ", 32'(bus.occupancy), 32'd2);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_occ", 32'(bus.occupancy), 32'd0);
    chk("async_rst_err", 32'(bus.err_underflow), 32'd0);
    chk("async_rst_dec_ready", 32'(bus.dec_ready), 32'd1);
    step();
    rst_n = 1'b1;
    rslv(1'b0, 1'b0, 32'h0, 32'h904, 1'b0, 3'd0, 1'b0);
    step();
    chk("post_rst_no_pending_err", 32'(bus.err_underflow), 32'd1);
    chk("post_rst_res_ready", 32'(bus.res_ready), 32'd1);

    // randomized traffic against the queue model
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    mq.delete();
    m_pend = 0; m_wait = 0; m_flush = 0; m_err = 0;

    for (int c = 0; c < 3000; c++) begin
      bit          rready, dready, acc, mis, npend;
      logic        rv, tk, csr, comp, rat;
      logic [1:0]  dv, db;
      logic [31:0] pc0, pc1, tgt, rpc, cpc, h;
      logic [2:0]  tkt;
      int          presz, r;

      rready = !m_wait && !m_flush;
      dready = (DP - mq.size()) >= FW;

      r  = $urandom_range(0, 3);
      dv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      db = 2'($urandom_range(0, 3));
      pc0 = 32'($urandom_range(0, 255)) << 2;
      if (m_wait && $urandom_range(0, 1) == 1) pc0 = m_spc;
      pc1 = pc0 + 32'd4;
      rv  = rready ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 6) == 0);
      tk  = 1'($urandom_range(0, 1));
      csr = ($urandom_range(0, 19) == 0);
      comp = 1'($urandom_range(0, 1));
      tgt = 32'($urandom_range(0, 255)) << 2;
      rpc = 32'($urandom_range(0, 255)) << 2;
      tkt = 3'($urandom_range(0, 7));
      rat = 1'($urandom_range(0, 1));
      if (!m_wait && mq.size() > 0 && !csr && $urandom_range(0, 9) < 7) begin
        if (tk) tgt = mq[0];
        else    rpc = mq[0] - (comp ? 32'd2 : 32'd4);
      end
      drive(dv, db, pc0, pc1, rv, tk, csr, tgt, rpc, comp, tkt, rat);

      acc   = (dv != 2'b00) && dready;
      presz = mq.size();
      npend = 1'b0;
      if (acc) begin
        if (m_pend) mq.push_back(pc0);
        if (dv[0] && db[0] && dv[1]) mq.push_back(pc1);
        npend = dv[1] ? db[1] : db[0];
      end
      cpc = (tk || csr) ? tgt : rpc + (comp ? 32'd2 : 32'd4);
      mis = 1'b0;
      if (m_wait) begin
        if (mq.size() > 0) begin
          h = mq.pop_front();
          mis = (h != m_spc);
          m_wait = 0;
          m_fpc = m_spc; m_ftk = m_stk; m_frat = m_srat;
        end
      end else if (rv && rready) begin
        m_fpc = cpc; m_ftk = tkt; m_frat = rat;
        if (csr) mis = 1'b1;
        else if (presz > 0) begin
          h = mq.pop_front();
          mis = (h != cpc);
        end else if (m_pend) begin
          m_wait = 1; m_spc = cpc; m_stk = tkt; m_srat = rat;
        end else m_err = 1;
      end
      if (mis) begin
        mq.delete();
        m_pend = 0;
        m_wait = 0;
      end else if (acc) m_pend = npend;
      m_flush = mis;

      step();
      chk($sformatf("rnd%0d_flush", c), 32'(bus.flush), 32'(m_flush));
      if (m_flush) begin
        chk($sformatf("rnd%0d_flush_pc", c), bus.flush_pc, m_fpc);
        chk($sformatf("rnd%0d_ticket", c), 32'(bus.flush_ticket), 32'(m_ftk));
        chk($sformatf("rnd%0d_rat", c), 32'(bus.flush_rat_id), 32'(m_frat));
      end
      chk($sformatf("rnd%0d_occ", c), 32'(bus.occupancy), 32'(mq.size()));
      chk($sformatf("rnd%0d_err", c), 32'(bus.err_underflow), 32'(m_err));
      chk($sformatf("rnd%0d_dec_ready", c), 32'(bus.dec_ready), ((DP - mq.size()) >= FW) ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d_res_ready", c), 32'(bus.res_ready), (!m_wait && !m_flush) ? 32'd1 : 32'd0);
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
